// File: rtl/mux16_demux_assembler.sv
// mux16_demux_assembler
// Rebuilds a 16-bit word from (sel, bit) samples taken at the output of a
// 16-to-1 select path. Every sample is written into its own lane. A mask
// records which lanes are filled. Once all lanes are filled, the word is
// held on a valid/ready output until the consumer takes it.

module mux16_demux_assembler #(
   parameter int N    = 16,
   parameter int SELW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [SELW-1:0] in_sel,
   input  logic            in_bit,
   output logic            in_ready,
   input  logic            abort,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    dout,
   output logic            out_dup,
   output logic [SELW:0]   fill_cnt
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Fill count just before the last distinct lane arrives.
   localparam logic [SELW:0] LAST_CNT = (SELW+1)'(N-1);

   state_t            state_reg;
   state_t            state_next;
   logic [N-1:0]      data_reg;
   logic [N-1:0]      mask_reg;
   logic [SELW:0]     fill_cnt_reg;
   logic              dup_reg;

   logic              accept;
   logic              handshake;
   logic              clear;
   logic              lane_hit;
   logic              complete;
   logic [N-1:0]      lane_wr;

   // Abort only has an effect while collecting. A finished word is always delivered.
   assign accept    = in_valid & in_ready & ~abort;
   assign handshake = out_valid & out_ready;
   assign clear     = handshake | (abort & (state_reg == COLLECT));
   assign lane_hit  = mask_reg[in_sel];
   assign complete  = accept & ~lane_hit & (fill_cnt_reg == LAST_CNT);
   assign lane_wr   = accept ? (N'(1) << in_sel) : '0;

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= COLLECT;
      else
         state_reg <= state_next;
   end

   // Next-state logic: fill the last lane -> HOLD; consumer takes the word -> COLLECT
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COLLECT: if (complete)  state_next = HOLD;
         HOLD:    if (out_ready) state_next = COLLECT;
         default:                state_next = COLLECT;
      endcase
   end

   // Output decode: ready while collecting, valid while holding (no skid buffer)
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_reg)
         COLLECT: in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Per-lane storage. The last write to a lane wins, and clear empties every lane.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (rst) begin
               data_reg[gi] <= 1'b0;
               mask_reg[gi] <= 1'b0;
            end else if (clear) begin
               data_reg[gi] <= 1'b0;
               mask_reg[gi] <= 1'b0;
            end else if (lane_wr[gi]) begin
               data_reg[gi] <= in_bit;
               mask_reg[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   // Distinct-lane count and sticky duplicate flag for the word being built
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt_reg <= '0;
         dup_reg      <= 1'b0;
      end else if (clear) begin
         fill_cnt_reg <= '0;
         dup_reg      <= 1'b0;
      end else if (accept) begin
         if (lane_hit)
            dup_reg <= 1'b1;
         else
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
      end
   end

   assign dout     = data_reg;
   assign out_dup  = dup_reg;
   assign fill_cnt = fill_cnt_reg;

endmodule

// File: tb/tb_mux16_demux_assembler.sv
// tb_mux16_demux_assembler
// Table-driven bench. Each record holds the inputs for one clock edge and the
// outputs expected just after that edge. Multi-cycle sequences (fills, dup,
// abort, mid-word reset) are expanded into records by small helper tasks.

module tb_mux16_demux_assembler;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [3:0]  sel;
      logic        b;
      logic        ab;
      logic        ordy;
      logic        e_valid;
      logic        e_ready;
      logic        chk_dout;
      logic [15:0] e_dout;
      logic        e_dup;
      logic [4:0]  e_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_sel;
   logic        in_bit;
   logic        in_ready;
   logic        abort;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;
   logic        out_dup;
   logic [4:0]  fill_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   mux16_demux_assembler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sel    (in_sel),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_dup   (out_dup),
      .fill_cnt  (fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic iv, input logic [3:0] sel, input logic b,
                      input logic ab, input logic ordy, input logic ev, input logic er,
                      input logic cd, input logic [15:0] ed, input logic edup,
                      input logic [4:0] ecnt);
      vec_t v;
      v.rst = r; v.iv = iv; v.sel = sel; v.b = b; v.ab = ab; v.ordy = ordy;
      v.e_valid = ev; v.e_ready = er; v.chk_dout = cd; v.e_dout = ed;
      v.e_dup = edup; v.e_cnt = ecnt;
      vecs.push_back(v);
   endtask

   // Reset cycle: every output is at its reset value afterwards.
   task automatic add_reset();
      add(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);
   endtask

   // Idle cycle while collecting: nothing is presented, so the expected state is unchanged.
   task automatic add_idle(input logic [4:0] cnt, input logic dup);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, dup, cnt);
   endtask

   // Present n distinct lanes of word w, one per cycle.
   // Lane order: mode 0 = ascending, 1 = descending, 2 = (5*i+3) mod 16.
   // The lane named by skip is left out. Use 16 when no lane is skipped.
   // dout is checked only once the word is complete.
   task automatic add_fill(input logic [15:0] w, input int mode, input int n,
                           input logic ordy, input int base, input logic dup, input int skip);
      int done = 0;
      for (int i = 0; i < 16; i++) begin
         int lane;
         int cnt;
         bit full;
         lane = (mode == 0) ? i : (mode == 1) ? 15 - i : (5 * i + 3) % 16;
         if (lane == skip || done >= n) continue;
         done++;
         cnt  = base + done;
         full = (cnt == 16);
         add(1'b0, 1'b1, 4'(lane), w[lane], 1'b0, ordy, full, !full, full, w, dup, 5'(cnt));
      end
   endtask

   task automatic check1(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bit = 1'b0; abort = 1'b0; out_ready = 1'b0;

      // Reset, held for 2 cycles
      add_reset();
      add_reset();

      // In-order fill of 3f0a with out_ready low. Then 3 cycles of ignored samples
      // while holding, then a handshake with a sample that must not be accepted.
      add_fill(16'h3f0a, 0, 16, 1'b0, 0, 1'b0, 16);
      for (int k = 0; k < 3; k++)
         add(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3f0a, 1'b0, 5'd16);
      add(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);
      add_idle(5'd0, 1'b0);

      // Reverse-order fill of A5C3 with out_ready held high. out_valid lasts one cycle.
      add_fill(16'hA5C3, 1, 16, 1'b1, 0, 1'b0, 16);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);

      // Duplicate lane 6 (1, then 0). The last write wins, and the count stays 1.
      add(1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd1);
      add(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 5'd1);
      add_fill(16'h3f0a, 0, 15, 1'b0, 1, 1'b1, 6);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);

      // Abort in COLLECT with a simultaneous sample; the sample is discarded.
      add_fill(16'h3f0a, 0, 8, 1'b0, 0, 1'b0, 16);
      add(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);
      add_fill(16'h1234, 0, 16, 1'b0, 0, 1'b0, 16);
      // Abort in HOLD is ignored, and the word is delivered unchanged.
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 5'd16);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);

      // Reset at fill_cnt=10, then reset during HOLD, then a permuted fill of FFFF.
      add_fill(16'h5555, 0, 10, 1'b0, 0, 1'b0, 16);
      add_reset();
      add_fill(16'hBEEF, 2, 16, 1'b0, 0, 1'b0, 16);
      add_reset();
      add_fill(16'hFFFF, 2, 16, 1'b0, 0, 1'b0, 16);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 5'd0);

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         in_valid  = vecs[i].iv;
         in_sel    = vecs[i].sel;
         in_bit    = vecs[i].b;
         abort     = vecs[i].ab;
         out_ready = vecs[i].ordy;
         @(posedge clk);
         #1;
         $display("vec %0d rst=%b iv=%b sel=%0d bit=%b ab=%b ordy=%b -> ov=%b ir=%b dout=%h dup=%b cnt=%0d",
                  i, vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].b, vecs[i].ab, vecs[i].ordy,
                  out_valid, in_ready, dout, out_dup, fill_cnt);
         check1("out_valid", i, 16'(out_valid), 16'(vecs[i].e_valid));
         check1("in_ready",  i, 16'(in_ready),  16'(vecs[i].e_ready));
         check1("out_dup",   i, 16'(out_dup),   16'(vecs[i].e_dup));
         check1("fill_cnt",  i, 16'(fill_cnt),  16'(vecs[i].e_cnt));
         if (vecs[i].chk_dout)
            check1("dout", i, dout, vecs[i].e_dout);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux16_demux_assembler.md
Name: mux16_demux_assembler

Overview:
- Receiving end of the 16-to-1 select path. The 16-to-1 mux presents one bit of a 16-bit word per select value; this block takes those (sel, bit) samples, writes each bit into its lane, and tracks which lanes are filled.
- When all 16 lanes are filled, it presents the rebuilt word on a valid/ready output.
- Sits directly downstream of the mux select/output pair and feeds a word-wide consumer.

Parameters:
- N, 16, number of lanes (word width). Fixed at 16 in this block.
- SELW, 4, select width. Fixed, log2(N).

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample present
- in_sel  input  4  lane index of sample
- in_bit  input  1  sample bit value (mux f)
- in_ready  output  1  block accepts a sample this cycle
- abort  input  1  discard the partially assembled word
- out_valid  output  1  assembled word available
- out_ready  input  1  consumer takes the word
- dout  output  16  assembled word
- out_dup  output  1  at least one lane of this word was written more than once
- fill_cnt  output  5  number of distinct lanes filled, 0..16

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset values: out_valid=0, dout=16'h0000, out_dup=0, fill_cnt=0, internal lane mask=0. in_ready is combinational and is 1 after reset.
- Reset has priority over every other input, including mid-word and while out_valid=1. Any pending word is lost.
- States:
  - COLLECT: out_valid=0.
  - HOLD: out_valid=1.
- in_ready = 1 in COLLECT and 0 in HOLD. There is no skid buffer.
- Accept = in_valid & in_ready & ~abort.
- On accept:
  - data[in_sel] <= in_bit.
  - mask[in_sel] <= 1.
  - If mask[in_sel] was already 1: out_dup <= 1 (sticky until the word is delivered) and fill_cnt is unchanged.
  - Otherwise fill_cnt increments by 1.
  - The last write to a lane wins.
- Completion: an accept that fills the 16th distinct lane moves the block to HOLD at the same edge.
  - out_valid=1 the cycle after that accept edge.
  - dout equals the full word, including the bit just written. Latency is 1 cycle.
- In COLLECT, dout shows the partial word and is a don't-care to consumers.
- In HOLD, dout, out_dup and fill_cnt=16 are stable until the handshake. in_valid samples are ignored (not accepted, no state change).
- Handshake: out_valid & out_ready at an edge returns the block to COLLECT and clears data=0, mask=0, fill_cnt=0, out_dup=0.
  - in_ready rises the following cycle.
  - A sample presented in the handshake cycle is not accepted.
- abort:
  - In COLLECT: clears data, mask, fill_cnt and out_dup at the edge. A simultaneous in_valid sample is discarded; abort wins.
  - In HOLD: abort is ignored. A completed word is always delivered.
- out_ready while out_valid=0 has no effect.
- in_sel has no ordering requirement; any permutation of lanes completes the word.

Test Plan:
- Reset: assert rst 2 cycles -> out_valid=0, dout=16'h0000, fill_cnt=0, out_dup=0, in_ready=1.
- In-order fill:
  - Stimulus: sel 0..15 with bits of 16'h3f0a, out_ready=0.
  - Response: out_valid=1 one cycle after the 16th accept, dout=16'h3f0a, out_dup=0, in_ready=0.
  - Then hold in_valid=1 (sel=0, bit=1) for 3 cycles -> dout stays 3f0a.
  - Then pulse out_ready -> out_valid=0, fill_cnt=0 next cycle.
- Reverse order:
  - Stimulus: sel 15 down to 0 with bits of 16'hA5C3, out_ready held 1.
  - Response: dout=16'hA5C3 for exactly one cycle of out_valid; in_ready returns to 1.
- Duplicate lane:
  - Stimulus: sel 6 bit=1, then sel 6 bit=0, then the remaining 15 lanes of 16'h3f0a.
  - Response: fill_cnt=1 after both sel 6 writes; final dout=16'h3f0a, out_dup=1.
  - After the handshake: out_dup=0.
- Abort:
  - Stimulus: 8 lanes written (fill_cnt=8), then abort together with in_valid (sel=9).
  - Response: fill_cnt=0 next cycle. A fresh 16-lane fill of 16'h1234 yields dout=16'h1234.
  - Abort asserted in HOLD -> word still delivered unchanged.
- Reset mid-operation: rst at fill_cnt=10, and separately during HOLD -> all outputs return to reset values next cycle. A subsequent full fill of 16'hFFFF gives dout=16'hFFFF.
